ov7670_fb_writer: RTL
=====================

# ov7670_fb_writer

Capture-side controller for the camera frame buffer. It samples the OV7670 8-bit pixel bus (VSYNC/HREF/D) in the pixel-clock domain and assembles byte pairs into RGB565 words. It generates sequential write addresses and drives the write port of the dual-port frame-buffer RAM. It captures exactly one frame per request, crops to the configured window, and reports completion and geometry errors to the consumer.

## Interface
- `H_PIXELS`, 320: pixels per stored line. Excess pixels in a line are dropped.
- `V_LINES`, 240: lines per stored frame. Excess lines are dropped.
- `ADDR_WIDTH`, 17: RAM address width. Must satisfy 2**ADDR_WIDTH ≥ H_PIXELS*V_LINES (elaboration assertion).
- `clk` in 1: camera pixel clock (PCLK). The only clock.
- `rst` in 1: asynchronous, active-high reset.
- `cam_vsync` in 1: camera VSYNC, active high.
- `cam_href` in 1: camera HREF, active high.
- `cam_d` in 8: camera data byte.
- `capture_req` in 1: single-cycle request to arm capture of the next full frame.
- `abort` in 1: cancel the capture in progress.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_WIDTH: RAM write address.
- `ram_di` out 16: RGB565 word, first byte in [15:8].
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: 1-cycle pulse when a frame ends.
- `frame_err` out 1: sticky; valid from `frame_done` until the next accepted `capture_req`.
- `lines_seen` out 10: number of lines counted in the last frame, saturating at 1023.

## Operation
- Input stage: `cam_vsync`, `cam_href` and `cam_d` are registered once. Edge detection uses the registered copy against a second registered copy.
- States:
  - IDLE → WAIT_VS on `capture_req`.
  - WAIT_VS → WAIT_END on a vsync rising edge. This is the blanking of the frame currently in flight.
  - WAIT_END → CAPTURE on a vsync falling edge.
  - CAPTURE → DONE on a vsync rising edge.
  - DONE → IDLE unconditionally after 1 cycle.
- `abort` forces IDLE from any state on the next edge. No `frame_done`, no further writes. `abort` beats `capture_req` in the same cycle.
- `capture_req` while `busy` is ignored.
- Byte assembly in CAPTURE while registered href=1:
  - `phase` toggles every cycle.
  - phase 0: latch the byte as the high byte.
  - phase 1: form the word; write it if x < H_PIXELS and y < V_LINES.
- Addressing uses no multiplier:
  - `ram_addr` = `line_base` + x.
  - At href falling edge: x←0, phase←0.
  - If the line had ≥1 byte: y+1, and `line_base` += H_PIXELS (saturating at V_LINES).
  - Short lines leave the unwritten words holding stale data.
- `frame_err` is set at DONE if any of these held:
  - any counted line had x ≠ H_PIXELS;
  - a line ended with phase=1 (odd byte count);
  - lines ≠ V_LINES.
- A vsync rising edge while href=1 ends the frame. The partial line counts as a line and is checked as above.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- Write latency: second byte on pins in cycle n → `ram_we`=1 with the matching `ram_addr`/`ram_di` in cycle n+2. All outputs are registered.
- `ram_we` is high for exactly 1 cycle per stored pixel. At most one write every 2 cycles.
- `frame_done` is asserted in the DONE cycle, 2 cycles after the vsync rising edge appears on the pins.
- `lines_seen` and `frame_err` are updated in the same cycle as `frame_done` and held until the next accepted request clears them.
- Address wrap is impossible by construction: the maximum address is H_PIXELS*V_LINES−1.

## Structure
- Shared package `fb_pkg` holds:
  - `fb_state_t` enum (IDLE, WAIT_VS, WAIT_END, CAPTURE, DONE);
  - `rgb565_t` packed struct (r5, g6, b5);
  - localparams for the default QVGA geometry.
- Sub-module `ov7670_in_sync`: registered input stage plus rise/fall strobes for vsync and href. Everything else is a single module.

## Test plan
Use H_PIXELS=4, V_LINES=3, ADDR_WIDTH=4.

- Nominal: request, then 3 lines of 8 bytes 0x00..0x17 → 12 writes at addresses 0..11, word 0 = 0x0001, word 11 = 0x1617; `frame_done` once; `frame_err`=0; `lines_seen`=3.
- Request arrives mid-frame (vsync low, href active) → no writes until after the next vsync high→low; then a full frame is captured normally.
- Long line of 10 bytes plus a 4th line → writes only at x<4 and y<3; `frame_err`=1; `lines_seen`=4.
- Short line of 6 bytes followed by a 7-byte line → line 1 writes addresses 4..6, line 2 starts at address 8; `frame_err`=1.
- `abort` 2 cycles after the first write → `busy` low next cycle; no further `ram_we`; no `frame_done`. A new `capture_req` is accepted afterwards.
- Async `rst` asserted during CAPTURE → all outputs 0 immediately, state IDLE; `capture_req` in the same cycle as `abort` → stays IDLE.

Source files
------------

// File: rtl/ov7670_fb_writer_pkg.sv
// Shared types and default geometry for the OV7670 frame-buffer capture path.
package fb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        WAIT_END,
        CAPTURE,
        DONE
    } fb_state_t;

    typedef struct packed {
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
    } rgb565_t;

    localparam int QVGA_H_PIXELS   = 320;
    localparam int QVGA_V_LINES    = 240;
    localparam int QVGA_ADDR_WIDTH = 17;

    // The camera sends the red/green-high byte first.
    function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
        return rgb565_t'({hi, lo});
    endfunction

endpackage

// File: rtl/ov7670_in_sync.sv
// Registers the raw camera bus once and derives edge strobes from a second copy.
module ov7670_in_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_d,
    output logic       href,
    output logic [7:0] d,
    output logic       vsync_rise,
    output logic       vsync_fall,
    output logic       href_fall
);

    logic vsync_q;
    logic vsync_q2;
    logic href_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q  <= 1'b0;
            href     <= 1'b0;
            d        <= 8'h00;
            vsync_q2 <= 1'b0;
            href_q2  <= 1'b0;
        end else begin
            vsync_q  <= cam_vsync;
            href     <= cam_href;
            d        <= cam_d;
            vsync_q2 <= vsync_q;
            href_q2  <= href;
        end
    end

    assign vsync_rise = vsync_q & ~vsync_q2;
    assign vsync_fall = ~vsync_q & vsync_q2;
    assign href_fall  = ~href & href_q2;

endmodule

// File: rtl/ov7670_fb_writer.sv
// Captures one cropped OV7670 frame per request into the frame-buffer write port
// as RGB565 words, reporting completion, line count and geometry errors.
module ov7670_fb_writer
    import fb_pkg::*;
#(
    parameter int H_PIXELS   = QVGA_H_PIXELS,
    parameter int V_LINES    = QVGA_V_LINES,
    parameter int ADDR_WIDTH = QVGA_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cam_vsync,
    input  logic                  cam_href,
    input  logic [7:0]            cam_d,
    input  logic                  capture_req,
    input  logic                  abort,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [15:0]           ram_di,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [9:0]            lines_seen
);

    localparam int XW = $clog2(H_PIXELS + 2);
    localparam int YW = $clog2(V_LINES + 1);

    localparam logic [XW-1:0]         X_FULL    = XW'(H_PIXELS);
    localparam logic [XW-1:0]         X_SAT     = XW'(H_PIXELS + 1);
    localparam logic [YW-1:0]         Y_FULL    = YW'(V_LINES);
    localparam logic [YW-1:0]         Y_LAST    = YW'(V_LINES - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_STEP = ADDR_WIDTH'(H_PIXELS);
    localparam logic [9:0]            V_LINES10 = 10'(V_LINES);

    if ((64'd1 << ADDR_WIDTH) < (64'(H_PIXELS) * 64'(V_LINES))) begin : g_addr_check
        $error("ov7670_fb_writer: ADDR_WIDTH cannot hold H_PIXELS*V_LINES words");
    end

    logic       href;
    logic [7:0] d;
    logic       vsync_rise;
    logic       vsync_fall;
    logic       href_fall;

    ov7670_in_sync u_in_sync (
        .clk        (clk),
        .rst        (rst),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_d      (cam_d),
        .href       (href),
        .d          (d),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .href_fall  (href_fall)
    );

    fb_state_t             state;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [ADDR_WIDTH-1:0] line_base;
    logic                  phase;
    logic [7:0]            hi_byte;
    logic [9:0]            line_count;
    logic                  line_err;

    logic                  line_has_bytes;
    logic                  line_bad;
    logic [9:0]            lines_final;
    logic                  err_final;

    // Closing view of the line in progress, used both at href fall and when vsync cuts a line short.
    always_comb begin
        line_has_bytes = (x != '0) || phase;
        line_bad       = (x != X_FULL) || phase;
        lines_final    = line_count;
        if (line_has_bytes && (line_count != 10'h3FF)) begin
            lines_final = line_count + 10'd1;
        end
        err_final = line_err || (line_has_bytes && line_bad) || (lines_final != V_LINES10);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_di     <= 16'h0000;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            lines_seen <= 10'd0;
            x          <= '0;
            y          <= '0;
            line_base  <= '0;
            phase      <= 1'b0;
            hi_byte    <= 8'h00;
            line_count <= 10'd0;
            line_err   <= 1'b0;
        end else begin
            ram_we     <= 1'b0;
            frame_done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (capture_req) begin
                            state      <= WAIT_VS;
                            busy       <= 1'b1;
                            frame_err  <= 1'b0;
                            lines_seen <= 10'd0;
                        end
                    end
                    WAIT_VS: begin
                        if (vsync_rise) begin
                            state <= WAIT_END;
                        end
                    end
                    WAIT_END: begin
                        if (vsync_fall) begin
                            state      <= CAPTURE;
                            x          <= '0;
                            y          <= '0;
                            line_base  <= '0;
                            phase      <= 1'b0;
                            line_count <= 10'd0;
                            line_err   <= 1'b0;
                        end
                    end
                    CAPTURE: begin
                        if (vsync_rise) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            frame_err  <= err_final;
                            lines_seen <= lines_final;
                        end else if (href_fall) begin
                            x     <= '0;
                            phase <= 1'b0;
                            if (line_has_bytes) begin
                                line_count <= lines_final;
                                line_err   <= line_err || line_bad;
                                if (y != Y_FULL) begin
                                    y <= y + 1'b1;
                                end
                                // Base stops at the last stored line; rows beyond it are never written.
                                if (y < Y_LAST) begin
                                    line_base <= line_base + BASE_STEP;
                                end
                            end
                        end else if (href) begin
                            phase <= ~phase;
                            if (!phase) begin
                                hi_byte <= d;
                            end else begin
                                if (x != X_SAT) begin
                                    x <= x + 1'b1;
                                end
                                if ((x < X_FULL) && (y < Y_FULL)) begin
                                    ram_we   <= 1'b1;
                                    ram_addr <= line_base + ADDR_WIDTH'(x);
                                    ram_di   <= pack_rgb565(hi_byte, d);
                                end
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
